// File: rtl/pipe_ir_sequencer.sv
// Pipeline IR / CDEC flag / PC sequencer for the 5-stage core, with the IJMP refill FSM.
// Optional perf counters (retired, stalls, flushes) are built when PIPE_SEQ_PERF_EN is defined.
module pipe_ir_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOOP     = 32'h0000_0020,
  parameter logic [5:0]  CDEC_OP  = 6'b110000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        ijmpMem,
  input  logic [31:0] ijmp_target,
  input  logic        cdec_flag_ex,
  output logic [31:0] pc,
  output logic [31:0] IFIDIR,
  output logic [31:0] IDEXIR,
  output logic [31:0] EXMEMIR,
  output logic [31:0] MEMWBIR,
  output logic        EXMEMFlagOut,
  output logic        MEMWBFlagOut,
  output logic        refilling
`ifdef PIPE_SEQ_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic {RUN, REFILL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  fillCnt_q, fillCnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_q, ifid_d;
  logic [31:0] idex_q, idex_d;
  logic [31:0] exmem_q, exmem_d;
  logic [31:0] memwb_q, memwb_d;
  logic        exFlag_q, exFlag_d;
  logic        wbFlag_q, wbFlag_d;

  // Redirect beats stall; a stall freezes fetch/decode and bubbles IDEX only.
  always_comb begin
    pc_d     = pc_q + 32'd4;
    ifid_d   = imem_data;
    idex_d   = ifid_q;
    exmem_d  = idex_q;
    memwb_d  = exmem_q;
    exFlag_d = (idex_q[31:26] == CDEC_OP) && cdec_flag_ex;
    wbFlag_d = exFlag_q;
    if (ijmpMem) begin
      pc_d     = ijmp_target & ~32'd3;
      ifid_d   = NOOP;
      idex_d   = NOOP;
      exmem_d  = NOOP;
      exFlag_d = 1'b0;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = NOOP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ifid_q   <= NOOP;
      idex_q   <= NOOP;
      exmem_q  <= NOOP;
      memwb_q  <= NOOP;
      exFlag_q <= 1'b0;
      wbFlag_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      idex_q   <= idex_d;
      exmem_q  <= exmem_d;
      memwb_q  <= memwb_d;
      exFlag_q <= exFlag_d;
      wbFlag_q <= wbFlag_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      fillCnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      fillCnt_q <= fillCnt_d;
    end
  end

  // The refill window only counts down on cycles that actually advance.
  always_comb begin
    state_d   = state_q;
    fillCnt_d = fillCnt_q;
    case (state_q)
      RUN: begin
        if (ijmpMem) begin
          state_d   = REFILL;
          fillCnt_d = 2'd3;
        end
      end
      REFILL: begin
        if (ijmpMem) begin
          fillCnt_d = 2'd3;
        end else if (!stall) begin
          fillCnt_d = fillCnt_q - 2'd1;
          if (fillCnt_q == 2'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d   = RUN;
        fillCnt_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    refilling = (state_q == REFILL);
  end

  assign pc           = pc_q;
  assign IFIDIR       = ifid_q;
  assign IDEXIR       = idex_q;
  assign EXMEMIR      = exmem_q;
  assign MEMWBIR      = memwb_q;
  assign EXMEMFlagOut = exFlag_q;
  assign MEMWBFlagOut = wbFlag_q;

`ifdef PIPE_SEQ_PERF_EN
  logic [31:0] retired_q, stalls_q, flushes_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= 32'd0;
      stalls_q  <= 32'd0;
      flushes_q <= 32'd0;
    end else begin
      if (memwb_q != NOOP) retired_q <= retired_q + 32'd1;
      if (stall && !ijmpMem) stalls_q <= stalls_q + 32'd1;
      if (ijmpMem) flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_stalls  = stalls_q;
  assign perf_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_pipe_ir_sequencer.sv
// Directed bench for pipe_ir_sequencer: a vector table walked in a loop plus a hand-written
// stall/CDEC sequence. Perf counters are checked against a bench model when PIPE_SEQ_PERF_EN is defined.
module tb_pipe_ir_sequencer;

  localparam logic [31:0] N  = 32'h0000_0020;
  localparam logic [31:0] I0 = 32'h8C01_0000, I1 = 32'h0022_1820, I2 = 32'h0043_1022;
  localparam logic [31:0] I3 = 32'h0064_2024, I4 = 32'h0085_2825, I5 = 32'h00A6_3020;
  localparam logic [31:0] I6 = 32'h00C7_3822, I7 = 32'h00E8_4024, IJ = 32'h7C00_0008;
  localparam logic [31:0] T0 = 32'h1000_0001, T1 = 32'h1000_0002, T2 = 32'h1000_0003;
  localparam logic [31:0] T3 = 32'h1000_0004, T4 = 32'h1000_0005;
  localparam logic [31:0] U0 = 32'h2000_0001, U1 = 32'h2000_0002, U2 = 32'h2000_0003;
  localparam logic [31:0] V0 = 32'h3000_0000, V1 = 32'h3000_0001, V2 = 32'h3000_0002;
  localparam logic [31:0] V3 = 32'h3000_0003, V4 = 32'h3000_0004, V5 = 32'h3000_0005;
  localparam logic [31:0] V6 = 32'h3000_0006, V7 = 32'h3000_0007;
  localparam logic [31:0] W0 = 32'h4000_0000, W1 = 32'h4000_0001, W2 = 32'h4000_0002;
  localparam logic [31:0] W3 = 32'h4000_0003, X0 = 32'h5000_0001, X1 = 32'h5000_0002;
  localparam logic [31:0] C  = 32'hC022_1800;

  typedef struct {
    logic        rst, stl, ij;
    logic [31:0] tgt, imem;
    logic        cdec;
    logic [31:0] pc, ifid, idex, exmem, memwb;
    logic        ef, mf, rf;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, stall, ijmpMem, cdec_flag_ex;
  logic [31:0] imem_data, ijmp_target;
  logic [31:0] pc, IFIDIR, IDEXIR, EXMEMIR, MEMWBIR;
  logic        EXMEMFlagOut, MEMWBFlagOut, refilling;
`ifdef PIPE_SEQ_PERF_EN
  logic [31:0] perf_retired, perf_stalls, perf_flushes;
  logic [31:0] mRetired, mStalls, mFlushes;
`endif

  int          nCompared = 0;
  int          nMismatched = 0;
  logic [31:0] curExpMw = N;
  vec_t        vecs[$];

  always #5 clock = ~clock;

  pipe_ir_sequencer dut (
    .clock(clock), .reset(reset), .imem_data(imem_data), .stall(stall),
    .ijmpMem(ijmpMem), .ijmp_target(ijmp_target), .cdec_flag_ex(cdec_flag_ex),
    .pc(pc), .IFIDIR(IFIDIR), .IDEXIR(IDEXIR), .EXMEMIR(EXMEMIR), .MEMWBIR(MEMWBIR),
    .EXMEMFlagOut(EXMEMFlagOut), .MEMWBFlagOut(MEMWBFlagOut), .refilling(refilling)
`ifdef PIPE_SEQ_PERF_EN
    , .perf_retired(perf_retired), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
  );

  task automatic addVec(input logic rst, stl, ij, input logic [31:0] tgt, imem, input logic cdec,
                        input logic [31:0] epc, eifid, eidex, eexmem, ememwb,
                        input logic ef, mf, rf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.ij = ij; v.tgt = tgt; v.imem = imem; v.cdec = cdec;
    v.pc = epc; v.ifid = eifid; v.idex = eidex; v.exmem = eexmem; v.memwb = ememwb;
    v.ef = ef; v.mf = mf; v.rf = rf;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge take them, sample 1ns later.
  task automatic applyStimulus(input logic rst, stl, ij, input logic [31:0] tgt, imem,
                               input logic cdec);
    @(negedge clock);
    reset = rst; stall = stl; ijmpMem = ij; ijmp_target = tgt;
    imem_data = imem; cdec_flag_ex = cdec;
`ifdef PIPE_SEQ_PERF_EN
    if (rst) begin
      mRetired = 0; mStalls = 0; mFlushes = 0;
    end else begin
      if (curExpMw != N) mRetired++;
      if (stl && !ij) mStalls++;
      if (ij) mFlushes++;
    end
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] epc, eifid, eidex, eexmem,
                             ememwb, input logic ef, mf, rf);
    cmp({tag, ".pc"}, pc, epc);
    cmp({tag, ".IFIDIR"}, IFIDIR, eifid);
    cmp({tag, ".IDEXIR"}, IDEXIR, eidex);
    cmp({tag, ".EXMEMIR"}, EXMEMIR, eexmem);
    cmp({tag, ".MEMWBIR"}, MEMWBIR, ememwb);
    cmp({tag, ".EXMEMFlag"}, {31'd0, EXMEMFlagOut}, {31'd0, ef});
    cmp({tag, ".MEMWBFlag"}, {31'd0, MEMWBFlagOut}, {31'd0, mf});
    cmp({tag, ".refilling"}, {31'd0, refilling}, {31'd0, rf});
`ifdef PIPE_SEQ_PERF_EN
    cmp({tag, ".perf_retired"}, perf_retired, mRetired);
    cmp({tag, ".perf_stalls"}, perf_stalls, mStalls);
    cmp({tag, ".perf_flushes"}, perf_flushes, mFlushes);
`endif
    curExpMw = ememwb;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ijmpMem = 1'b0; ijmp_target = 32'd0;
    imem_data = 32'd0; cdec_flag_ex = 1'b0;
`ifdef PIPE_SEQ_PERF_EN
    mRetired = 0; mStalls = 0; mFlushes = 0;
`endif

    //     rst stl ij  tgt            imem cdec  pc             ifid idex exmem memwb ef mf rf
    addVec(1, 0, 0, 32'h0,          I0, 0,  32'h0,          N,  N,  N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I0, 0,  32'h4,          I0, N,  N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I1, 0,  32'h8,          I1, I0, N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I2, 0,  32'hC,          I2, I1, I0, N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I3, 0,  32'h10,         I3, I2, I1, I0, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I4, 0,  32'h14,         I4, I3, I2, I1, 0, 0, 0);
    addVec(1, 0, 0, 32'h0,          I0, 0,  32'h0,          N,  N,  N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I0, 0,  32'h4,          I0, N,  N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I1, 0,  32'h8,          I1, I0, N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I2, 0,  32'hC,          I2, I1, I0, N,  0, 0, 0);
    addVec(0, 1, 0, 32'h0,          I3, 0,  32'hC,          I2, N,  I1, I0, 0, 0, 0);
    addVec(0, 1, 0, 32'h0,          I3, 0,  32'hC,          I2, N,  N,  I1, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I3, 0,  32'h10,         I3, I2, N,  N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I4, 0,  32'h14,         I4, I3, I2, N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          IJ, 0,  32'h18,         IJ, I4, I3, I2, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I5, 0,  32'h1C,         I5, IJ, I4, I3, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          I6, 0,  32'h20,         I6, I5, IJ, I4, 0, 0, 0);
    addVec(0, 0, 1, 32'h107,        I7, 0,  32'h104,        N,  N,  N,  IJ, 0, 0, 1);
    addVec(0, 0, 0, 32'h0,          T0, 0,  32'h108,        T0, N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          T1, 0,  32'h10C,        T1, T0, N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          T2, 0,  32'h110,        T2, T1, T0, N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          T3, 0,  32'h114,        T3, T2, T1, T0, 0, 0, 0);
    addVec(0, 1, 1, 32'h200,        T4, 0,  32'h200,        N,  N,  N,  T1, 0, 0, 1);
    addVec(0, 1, 0, 32'h0,          U0, 0,  32'h200,        N,  N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          U0, 0,  32'h204,        U0, N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          U1, 0,  32'h208,        U1, U0, N,  N,  0, 0, 1);
    addVec(0, 0, 1, 32'h300,        U2, 0,  32'h300,        N,  N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          V0, 0,  32'h304,        V0, N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          V1, 0,  32'h308,        V1, V0, N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          V2, 0,  32'h30C,        V2, V1, V0, N,  0, 0, 0);
    addVec(0, 0, 0, 32'h0,          C,  0,  32'h310,        C,  V2, V1, V0, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          V3, 1,  32'h314,        V3, C,  V2, V1, 0, 0, 0);
    addVec(0, 0, 0, 32'h0,          V4, 1,  32'h318,        V4, V3, C,  V2, 1, 0, 0);
    addVec(0, 0, 0, 32'h0,          V5, 1,  32'h31C,        V5, V4, V3, C,  0, 1, 0);
    addVec(0, 0, 0, 32'h0,          V6, 0,  32'h320,        V6, V5, V4, V3, 0, 0, 0);
    addVec(0, 0, 1, 32'hFFFF_FFFF,  V7, 0,  32'hFFFF_FFFC,  N,  N,  N,  V4, 0, 0, 1);
    addVec(1, 0, 0, 32'h0,          W0, 0,  32'h0,          N,  N,  N,  N,  0, 0, 0);
    addVec(0, 0, 1, 32'hFFFF_FFFC,  W0, 0,  32'hFFFF_FFFC,  N,  N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          W1, 0,  32'h0,          W1, N,  N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          W2, 0,  32'h4,          W2, W1, N,  N,  0, 0, 1);
    addVec(0, 0, 0, 32'h0,          W3, 0,  32'h8,          W3, W2, W1, N,  0, 0, 0);
    addVec(1, 1, 0, 32'h0,          W0, 0,  32'h0,          N,  N,  N,  N,  0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].stl, vecs[i].ij, vecs[i].tgt, vecs[i].imem, vecs[i].cdec);
      checkOutput($sformatf("row%0d", i), vecs[i].pc, vecs[i].ifid, vecs[i].idex,
                  vecs[i].exmem, vecs[i].memwb, vecs[i].ef, vecs[i].mf, vecs[i].rf);
    end

    // CDEC flag keeps flowing down EXMEM/MEMWB while decode is stalled.
    applyStimulus(0, 0, 0, 32'h0, C, 0);
    checkOutput("cdecStall1", 32'h4, C, N, N, N, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, X0, 0);
    checkOutput("cdecStall2", 32'h8, X0, C, N, N, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, X1, 1);
    checkOutput("cdecStall3", 32'h8, X0, N, C, N, 1, 0, 0);
    applyStimulus(0, 1, 0, 32'h0, X1, 0);
    checkOutput("cdecStall4", 32'h8, X0, N, N, C, 0, 1, 0);
    applyStimulus(0, 0, 0, 32'h0, X1, 0);
    checkOutput("cdecStall5", 32'hC, X1, X0, N, N, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
